// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host master slice.
package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;
    localparam logic [WB_DAT_W-1:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_host_if.sv
// Command/response handshake plus Wishbone classic master bus, bundled for wb_host_master.
interface wb_host_if
    import wb_host_pkg::*;
#(
    parameter int unsigned ADR_W = 32
);

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [ADR_W-1:0]    cmd_adr;
    logic [WB_DAT_W-1:0] cmd_dat;
    logic [WB_SEL_W-1:0] cmd_sel;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WB_DAT_W-1:0] rsp_dat;
    logic                rsp_err;

    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [ADR_W-1:0]    wbm_adr_o;
    logic [WB_DAT_W-1:0] wbm_dat_o;
    logic [WB_SEL_W-1:0] wbm_sel_o;
    logic                wbm_ack_i;
    logic [WB_DAT_W-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
        input  wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
        output wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

endinterface

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog: expired is high during the TIMEOUT_CYCLES-th enabled cycle since clear.
module wb_host_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding command-to-Wishbone classic master (IDLE -> BUS -> RESP).
// Optional bus timeout abort is enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADR_W          = 32
) (
    input  logic      wb_clk_i,
    input  logic      wb_rst_ni,
    wb_host_if.master bus
);

    state_t state, state_n;

    logic                accept;
    logic                done;
    logic                abort;
    logic                expired;

    logic                we_q;
    logic [ADR_W-1:0]    adr_q;
    logic [WB_DAT_W-1:0] dat_q;
    logic [WB_SEL_W-1:0] sel_q;
    logic [WB_DAT_W-1:0] rsp_dat_q;
    logic                rsp_err_q;

`ifdef WB_HOST_TIMEOUT_EN
    wb_host_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clear  (state != BUS),
        .enable (state == BUS),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Ack is checked before expiry so an ack in the expiry cycle completes normally.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_n = BUS;
                end
            end
            BUS: begin
                if (bus.wbm_ack_i) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else if (expired) begin
                    abort   = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                we_q  <= bus.cmd_we;
                adr_q <= bus.cmd_adr;
                dat_q <= bus.cmd_dat;
                sel_q <= bus.cmd_sel;
            end
            if (done) begin
                rsp_dat_q <= we_q ? '0 : bus.wbm_dat_i;
                rsp_err_q <= 1'b0;
            end else if (abort) begin
                rsp_dat_q <= TIMEOUT_RDATA;
                rsp_err_q <= 1'b1;
            end
        end
    end

    // Gated by reset so cmd_ready is low while reset is asserted even though state is IDLE.
    assign bus.cmd_ready = (state == IDLE) && wb_rst_ni;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;

    assign bus.wbm_cyc_o = (state == BUS);
    assign bus.wbm_stb_o = (state == BUS);
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master (TIMEOUT_CYCLES = 8); honours WB_HOST_TIMEOUT_EN.
module tb_wb_host_master;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    wb_host_if #(.ADR_W(32)) bus ();

    wb_host_master #(
        .TIMEOUT_CYCLES(8),
        .ADR_W         (32)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
    endtask

    initial begin
        int bad;
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_we     = 1'b0;
        bus.cmd_adr    = '0;
        bus.cmd_dat    = '0;
        bus.cmd_sel    = '0;
        bus.rsp_ready  = 1'b0;
        bus.wbm_ack_i  = 1'b0;
        bus.wbm_dat_i  = '0;

        // Reset state
        #3;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_cyc", bus.wbm_cyc_o, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_adr", bus.wbm_adr_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_cmd_ready", bus.cmd_ready, 1);

        // Write with two wait states
        set_cmd(1'b1, 32'h3000_0000, 32'hA5A5_5A5A, 4'hF);
        bus.wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr_cyc", bus.wbm_cyc_o, 1);
            check("wr_stb", bus.wbm_stb_o, 1);
            check("wr_cmd_ready", bus.cmd_ready, 0);
            check("wr_adr", bus.wbm_adr_o, 32'h3000_0000);
            check("wr_dat", bus.wbm_dat_o, 32'hA5A5_5A5A);
            check("wr_sel", bus.wbm_sel_o, 4'hF);
            check("wr_we", bus.wbm_we_o, 1);
            if (i == 2) bus.wbm_ack_i = 1'b1;
            tick();
        end
        bus.wbm_ack_i = 1'b0;
        check("wr_cyc_drop", bus.wbm_cyc_o, 0);
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_err", bus.rsp_err, 0);
        check("wr_rsp_dat", bus.rsp_dat, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("wr_idle_valid", bus.rsp_valid, 0);
        check("wr_idle_ready", bus.cmd_ready, 1);
        check("wr_adr_hold", bus.wbm_adr_o, 32'h3000_0000);

        // Zero-wait read; ack already high in IDLE must be ignored
        set_cmd(1'b0, 32'h3000_0004, 32'h0, 4'h3);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h1234_5678;
        tick();
        bus.cmd_valid = 1'b0;
        check("rd_bus_cyc", bus.wbm_cyc_o, 1);
        check("rd_bus_we", bus.wbm_we_o, 0);
        check("rd_bus_valid", bus.rsp_valid, 0);
        tick();
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_dat", bus.rsp_dat, 32'h1234_5678);
        check("rd_rsp_err", bus.rsp_err, 0);
        check("rd_cyc_drop", bus.wbm_cyc_o, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Response backpressure with a second command waiting
        set_cmd(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        bus.wbm_dat_i = 32'h0000_1111;
        tick();
        bus.cmd_adr = 32'h0000_0044;
        tick();
        bus.wbm_dat_i = 32'h0000_2222;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_dat", bus.rsp_dat, 32'h0000_1111);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_cyc", bus.wbm_cyc_o, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_idle_ready", bus.cmd_ready, 1);
        check("bp_idle_cyc", bus.wbm_cyc_o, 0);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp2_cyc", bus.wbm_cyc_o, 1);
        check("bp2_adr", bus.wbm_adr_o, 32'h0000_0044);
        tick();
        check("bp2_rsp_dat", bus.rsp_dat, 32'h0000_2222);
        bus.wbm_ack_i = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Ack arrives in the 8th BUS cycle (timeout expiry cycle)
        set_cmd(1'b0, 32'h0000_00C0, 32'h0, 4'hF);
        bus.wbm_dat_i = 32'h0000_00C3;
        tick();
        bus.cmd_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus.wbm_cyc_o !== 1'b1) bad++;
            tick();
        end
        check("race_cyc_held", bad, 0);
        check("race_cyc_last", bus.wbm_cyc_o, 1);
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("race_rsp_valid", bus.rsp_valid, 1);
        check("race_rsp_err", bus.rsp_err, 0);
        check("race_rsp_dat", bus.rsp_dat, 32'h0000_00C3);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // No ack at all
        set_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        tick();
        bus.cmd_valid = 1'b0;
`ifdef WB_HOST_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.wbm_cyc_o !== 1'b1) bad++;
            tick();
        end
        check("to_cyc_8", bad, 0);
        check("to_cyc_drop", bus.wbm_cyc_o, 0);
        check("to_rsp_valid", bus.rsp_valid, 1);
        check("to_rsp_err", bus.rsp_err, 1);
        check("to_rsp_dat", bus.rsp_dat, 32'hFFFF_FFFF);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        set_cmd(1'b0, 32'h0000_0200, 32'h0, 4'hF);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.wbm_cyc_o !== 1'b1 || bus.rsp_valid !== 1'b0) bad++;
            tick();
        end
        check("nto_cyc_1000", bad, 0);
`endif

        // Reset pulse mid-BUS
        check("mid_bus_cyc", bus.wbm_cyc_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_cyc", bus.wbm_cyc_o, 0);
        check("mr_stb", bus.wbm_stb_o, 0);
        check("mr_cmd_ready", bus.cmd_ready, 0);
        check("mr_adr", bus.wbm_adr_o, 0);
        #2 rst_n = 1'b1;
        #1;
        check("mr_rel_ready", bus.cmd_ready, 1);
        bus.wbm_ack_i = 1'b1;
        bus.rsp_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0) bad++;
        end
        check("mr_no_rsp", bad, 0);
        check("mr_final_ready", bus.cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum BUS cycles without ack before abort.
REQ-002 SHALL have parameter ADR_W, default 32: Wishbone address width.
REQ-003 SHALL have port wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port wb_rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when both high.
REQ-007 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_adr  input  ADR_W  byte address.
REQ-009 SHALL have port cmd_dat  input  32  write data.
REQ-010 SHALL have port cmd_sel  input  4  byte selects.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when both high.
REQ-013 SHALL have port rsp_dat  output  32  read data; 0 for writes.
REQ-014 SHALL have port rsp_err  output  1  transaction aborted by timeout.
REQ-015 SHALL have ports wbm_cyc_o / wbm_stb_o / wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-016 SHALL have ports wbm_adr_o  output  ADR_W, wbm_dat_o  output  32, wbm_sel_o  output  4  master bus fields.
REQ-017 SHALL have ports wbm_ack_i  input  1, wbm_dat_i  input  32  slave acknowledge and read data.

Function
REQ-018 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; one transaction outstanding at most.
REQ-019 IDLE: cmd_ready = 1; on cmd_valid & cmd_ready, latch we/adr/dat/sel and enter BUS next edge.
REQ-020 BUS: wbm_cyc_o = wbm_stb_o = 1, all bus fields driven from latched command and held stable; cmd_ready = 0.
REQ-021 BUS with wbm_ack_i sampled high: next edge drops cyc/stb, captures wbm_dat_i (reads) or 0 (writes) into rsp_dat, rsp_err = 0, enters RESP.
REQ-022 Zero-wait slave: rsp_valid SHALL assert exactly 2 cycles after the accepting edge; minimum 3 cycles per transaction.
REQ-023 RESP: rsp_valid = 1, rsp_dat/rsp_err stable until rsp_valid & rsp_ready; then IDLE; cmd_ready = 0.
REQ-024 wbm_ack_i outside BUS SHALL be ignored.
REQ-025 Outside BUS, cyc/stb SHALL be 0; adr/dat/sel/we hold last latched values.

Reset
REQ-026 wb_rst_ni low SHALL immediately (no clock) force IDLE, all outputs 0 incl. cmd_ready and cyc/stb; cmd_ready = 1 from first cycle after release.
REQ-027 Reset in BUS or RESP SHALL discard the transaction; no response issued afterwards.

Configuration
REQ-028 With WB_HOST_TIMEOUT_EN defined: BUS counts cycles; ack absent for TIMEOUT_CYCLES cycles -> drop cyc/stb, rsp_err = 1, rsp_dat = 32'hFFFF_FFFF, enter RESP; ack in the expiry cycle wins (normal completion).
REQ-029 Without WB_HOST_TIMEOUT_EN: no counter, BUS waits indefinitely, rsp_err tied 0, TIMEOUT_CYCLES unused.

Structure
REQ-030 Package wb_host_pkg SHALL hold the state enum {IDLE, BUS, RESP}, WB_DAT_W = 32, WB_SEL_W = 4, TIMEOUT_RDATA = 32'hFFFF_FFFF.
REQ-031 Sub-module wb_host_timeout (clear, enable, expired; width from TIMEOUT_CYCLES) SHALL be instantiated only under WB_HOST_TIMEOUT_EN.

Verification
REQ-032 Write adr 0x3000_0000, dat 0xA5A5_5A5A, sel 0xF, ack after 2 waits -> bus fields stable 3 cycles, rsp_valid, rsp_err 0, rsp_dat 0.
REQ-033 Read adr 0x3000_0004, zero-wait ack with 0x1234_5678 -> rsp_dat 0x1234_5678, rsp_valid 2 cycles after accept.
REQ-034 TIMEOUT_CYCLES = 8, no ack: macro on -> cyc drops after 8 BUS cycles, rsp_err 1, rsp_dat 0xFFFF_FFFF; macro off -> cyc high for 1000 cycles.
REQ-035 rsp_ready low 5 cycles with cmd_valid high -> rsp fields stable, cmd_ready 0, second command accepted only after response handshake.
REQ-036 wb_rst_ni pulsed low mid-BUS -> cyc/stb low before next edge, no rsp_valid after release, cmd_ready 1 first cycle after.
REQ-037 Ack coincident with timeout expiry (read 0x0000_00C3) -> rsp_err 0, rsp_dat 0x0000_00C3.
